axi_lite_slave_regs: RTL and testbench

//  AXI4-Lite slave register file; the downstream endpoint for axi_lite_master.
//  - Accepts single-beat writes (AW and W in any order or together) and returns B.
//  - Serves single-beat reads (AR -> R).
//  - Exposes all registers flat on regs_o to drive control logic.
//  - Word-addressed: index = addr[ADDR_W-1:2].

---
 rtl/axi_lite_slave_regs.sv | 128 ++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file with flat register outputs and per-register write pulses.
// Define AXIL_SLV_ERR_EN to answer out-of-range or misaligned addresses with SLVERR.
module axi_lite_slave_regs #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int STRB_W = DATA_W / 8;

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  int                wr_idx, rd_idx;
  logic              wr_legal, rd_legal;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Held values win over live bus values; both halves present means the write commits now.
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

`ifdef AXIL_SLV_ERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
  assign wr_idx   = int'(wr_addr[ADDR_W-1:2]);
  assign rd_idx   = int'(araddr[ADDR_W-1:2]);
  assign wr_legal = (wr_idx < NUM_REGS) && (wr_addr[1:0] == 2'b00);
  assign rd_legal = (rd_idx < NUM_REGS) && (araddr[1:0] == 2'b00);
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
  logic unused_addr_lsbs;
  assign wr_idx   = int'(wr_addr[ADDR_W-1:2]) % NUM_REGS;
  assign rd_idx   = int'(araddr[ADDR_W-1:2]) % NUM_REGS;
  assign wr_legal = 1'b1;
  assign rd_legal = 1'b1;
  assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      regs_o    <= '0;
      wr_pulse  <= '0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
    end else begin
      wr_pulse <= '0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_legal ? 2'b00 : ERR_RESP;
        if (wr_legal) begin
          wr_pulse[wr_idx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_o[wr_idx*DATA_W + b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  // Read data samples register contents before any write landing on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_legal ? regs_o[rd_idx*DATA_W +: DATA_W] : '0;
      rresp  <= rd_legal ? 2'b00 : ERR_RESP;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus randomized traffic
// checked against an array-based register model.
`timescale 1ns/1ps
module tb_axi_lite_slave_regs;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 4;
  localparam int STRB_W   = DATA_W / 8;

  logic                       aclk;
  logic                       aresetn;
  logic [ADDR_W-1:0]          awaddr;
  logic                       awvalid;
  logic                       awready;
  logic [DATA_W-1:0]          wdata;
  logic [STRB_W-1:0]          wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  logic [ADDR_W-1:0]          araddr;
  logic                       arvalid;
  logic                       arready;
  logic [DATA_W-1:0]          rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic [NUM_REGS-1:0]        wr_pulse;

  int checks = 0;
  int passes = 0;
  logic [DATA_W-1:0] model [NUM_REGS];

  axi_lite_slave_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse(wr_pulse)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain array of words, addressing rules taken from the register map.
  function automatic bit m_legal(input logic [ADDR_W-1:0] a);
`ifdef AXIL_SLV_ERR_EN
    return (int'(a[ADDR_W-1:2]) < NUM_REGS) && (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_idx(input logic [ADDR_W-1:0] a);
    return int'(a[ADDR_W-1:2]) % NUM_REGS;
  endfunction

  function automatic logic [1:0] m_resp(input logic [ADDR_W-1:0] a);
    return m_legal(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_pulse(input logic [ADDR_W-1:0] a);
    return m_legal(a) ? NUM_REGS'(1 << m_idx(a)) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] m_rdata(input logic [ADDR_W-1:0] a);
    return m_legal(a) ? model[m_idx(a)] : '0;
  endfunction

  function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                      input logic [STRB_W-1:0] s);
    if (m_legal(a))
      for (int b = 0; b < STRB_W; b++)
        if (s[b]) model[m_idx(a)][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] m_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = model[k];
    return f;
  endfunction

  // Drives AW and W with independent delays, then captures the B response and pulses.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output logic [NUM_REGS-1:0] pulse);
    int n;
    @(negedge aclk);
    fork
      begin
        int k;
        repeat (aw_dly) @(negedge aclk);
        awaddr = a; awvalid = 1'b1; k = 0;
        while (awready !== 1'b1 && k < 20) begin @(negedge aclk); k++; end
        if (k >= 20) begin
          checks++;
          $display("[TB] FAIL aw_timeout: awready=%b, required 1", awready);
        end
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) @(negedge aclk);
        wdata = d; wstrb = s; wvalid = 1'b1; k = 0;
        while (wready !== 1'b1 && k < 20) begin @(negedge aclk); k++; end
        if (k >= 20) begin
          checks++;
          $display("[TB] FAIL w_timeout: wready=%b, required 1", wready);
        end
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0;
      end
    join
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++;
      $display("[TB] FAIL b_timeout: bvalid=%b, required 1", bvalid);
    end
    resp  = bresp;
    pulse = wr_pulse;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output logic [1:0] resp);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++;
      $display("[TB] FAIL ar_timeout: arready=%b, required 1", arready);
    end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1; n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++;
      $display("[TB] FAIL r_timeout: rvalid=%b, required 1", rvalid);
    end
    d = rdata;
    resp = rresp;
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    model_clear();
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL reset_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) $display("[TB] FAIL reset_valids: got %b, required 00", {bvalid, rvalid});
    else passes++;
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      $display("[TB] FAIL reset_readies: got %b, required 111", {awready, wready, arready});
    else passes++;
    checks++;
    if ({wr_pulse, bresp, rresp, rdata} !== '0)
      $display("[TB] FAIL reset_outputs: got %h, required 0", {wr_pulse, bresp, rresp, rdata});
    else passes++;
    aresetn = 1'b1;
  endtask

  task automatic test_write_aw_first();
    logic [1:0] resp;
    logic [NUM_REGS-1:0] pulse;
    do_write(4'h4, 32'hDEAD_BEEF, 4'hF, 0, 2, resp, pulse);
    model_write(4'h4, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (regs_o[63:32] !== 32'hDEAD_BEEF) $display("[TB] FAIL aw_first_reg1: got %h, required deadbeef", regs_o[63:32]);
    else passes++;
    checks++;
    if ({resp, pulse} !== 6'b00_0010) $display("[TB] FAIL aw_first_b: got resp %b pulse %b, required 00 0010", resp, pulse);
    else passes++;
    checks++;
    if ({bvalid, wr_pulse} !== 5'b0_0000)
      $display("[TB] FAIL aw_first_oneshot: got bvalid %b pulse %b, required 0 0000", bvalid, wr_pulse);
    else passes++;
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp;
    logic [NUM_REGS-1:0] pulse;
    logic [DATA_W-1:0] d;
    do_write(4'h4, 32'h0000_00AA, 4'b0001, $urandom_range(0, 2), $urandom_range(0, 2), resp, pulse);
    model_write(4'h4, 32'h0000_00AA, 4'b0001);
    checks++;
    if (regs_o[63:32] !== 32'hDEAD_BEAA) $display("[TB] FAIL strobe_reg1: got %h, required deadbeaa", regs_o[63:32]);
    else passes++;
    do_read(4'h4, d, resp);
    checks++;
    if ({d, resp} !== {32'hDEAD_BEAA, 2'b00}) $display("[TB] FAIL strobe_read: got %h/%b, required deadbeaa/00", d, resp);
    else passes++;
  endtask

  task automatic test_zero_strobe();
    logic [1:0] resp;
    logic [NUM_REGS-1:0] pulse;
    do_write(4'h0, $urandom, 4'b0000, 1, 0, resp, pulse);
    checks++;
    if ({resp, pulse} !== 6'b00_0001) $display("[TB] FAIL zero_strobe_b: got resp %b pulse %b, required 00 0001", resp, pulse);
    else passes++;
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL zero_strobe_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
  endtask

  task automatic test_back_to_back_bp();
    logic [DATA_W-1:0] d2;
    d2 = $urandom;
    @(negedge aclk);
    bready = 1'b0;
    awaddr = 4'h8; awvalid = 1'b1;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        wvalid = 1'b0;
        awaddr = 4'h0;
      end
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00)
        $display("[TB] FAIL bp_hold cycle %0d: got bvalid/bresp/awready/wready %b, required 1_00_00", i,
                 {bvalid, bresp, awready, wready});
      else passes++;
    end
    model_write(4'h8, 32'h1234_5678, 4'hF);
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL bp_reg2: got %h, required %h", regs_o, m_flat());
    else passes++;
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({bvalid, awready} !== 2'b01) $display("[TB] FAIL bp_release: got bvalid/awready %b, required 01", {bvalid, awready});
    else passes++;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (awready !== 1'b0) $display("[TB] FAIL bp_second_aw_held: got awready %b, required 0", awready);
    else passes++;
    wdata = d2; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if ({bvalid, wr_pulse} !== {1'b1, m_pulse(4'h0)})
      $display("[TB] FAIL bp_second_commit: got bvalid/pulse %b, required %b", {bvalid, wr_pulse}, {1'b1, m_pulse(4'h0)});
    else passes++;
    model_write(4'h0, d2, 4'hF);
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL bp_second_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
  endtask

  task automatic test_read_backpressure();
    logic [1:0] resp;
    logic [NUM_REGS-1:0] pulse;
    logic [DATA_W-1:0] d;
    d = $urandom;
    do_write(4'hC, d, 4'hF, 0, 0, resp, pulse);
    model_write(4'hC, d, 4'hF);
    @(negedge aclk);
    rready = 1'b0;
    araddr = 4'hC; arvalid = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (i == 0) arvalid = 1'b0;
      checks++;
      if ({rvalid, rdata, rresp, arready} !== {1'b1, model[3], 2'b00, 1'b0})
        $display("[TB] FAIL rd_hold cycle %0d: got rvalid %b rdata %h rresp %b arready %b, required 1 %h 00 0",
                 i, rvalid, rdata, rresp, arready, model[3]);
      else passes++;
    end
    rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) $display("[TB] FAIL rd_release: got rvalid/arready %b, required 01", {rvalid, arready});
    else passes++;
  endtask

  task automatic test_addr_mode();
    logic [1:0] resp, exp_resp;
    logic [NUM_REGS-1:0] pulse, exp_pulse;
    logic [DATA_W-1:0] d, rd;
`ifdef AXIL_SLV_ERR_EN
    exp_resp = 2'b10; exp_pulse = 4'b0000;
`else
    exp_resp = 2'b00; exp_pulse = 4'b0001;
`endif
    d = $urandom;
    do_write(4'h2, d, 4'hF, 0, 1, resp, pulse);
    model_write(4'h2, d, 4'hF);
    checks++;
    if ({resp, pulse} !== {exp_resp, exp_pulse})
      $display("[TB] FAIL addr_mode_b: got resp %b pulse %b, required %b %b", resp, pulse, exp_resp, exp_pulse);
    else passes++;
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL addr_mode_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
    do_read(4'h2, rd, resp);
    checks++;
    if ({rd, resp} !== {m_rdata(4'h2), exp_resp})
      $display("[TB] FAIL addr_mode_read: got %h/%b, required %h/%b", rd, resp, m_rdata(4'h2), exp_resp);
    else passes++;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, rd;
    logic [STRB_W-1:0] s;
    logic [1:0] resp;
    logic [NUM_REGS-1:0] pulse;
    for (int i = 0; i < 40; i++) begin
      a = ADDR_W'($urandom_range(0, 15));
      d = $urandom;
      s = STRB_W'($urandom_range(0, 15));
      do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse);
      checks++;
      if ({resp, pulse} !== {m_resp(a), m_pulse(a)})
        $display("[TB] FAIL rand_write %0d addr %h: got resp %b pulse %b, required %b %b", i, a, resp, pulse,
                 m_resp(a), m_pulse(a));
      else passes++;
      model_write(a, d, s);
      if ($urandom_range(0, 1) == 1) begin
        a = ADDR_W'($urandom_range(0, 15));
        do_read(a, rd, resp);
        checks++;
        if ({rd, resp} !== {m_rdata(a), m_resp(a)})
          $display("[TB] FAIL rand_read %0d addr %h: got %h/%b, required %h/%b", i, a, rd, resp, m_rdata(a), m_resp(a));
        else passes++;
      end
    end
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL rand_final_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    int seen;
    d = $urandom;
    @(negedge aclk);
    awaddr = 4'h4; awvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (awready !== 1'b0) $display("[TB] FAIL mid_aw_held: got awready %b, required 0", awready);
    else passes++;
    aresetn = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({regs_o, bvalid, awready, wr_pulse} !== {m_flat(), 1'b0, 1'b1, 4'b0000})
      $display("[TB] FAIL mid_reset_state: got regs %h bvalid %b awready %b pulse %b", regs_o, bvalid, awready, wr_pulse);
    else passes++;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 1'b0;
    seen = 0;
    repeat (3) begin
      if (bvalid === 1'b1) seen++;
      @(negedge aclk);
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL mid_no_stale_commit: got %0d bvalid cycles, required 0", seen);
    else passes++;
    awaddr = 4'h8; awvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if ({bvalid, wr_pulse} !== {1'b1, m_pulse(4'h8)})
      $display("[TB] FAIL mid_recover_commit: got bvalid/pulse %b, required %b", {bvalid, wr_pulse}, {1'b1, m_pulse(4'h8)});
    else passes++;
    model_write(4'h8, d, 4'hF);
    @(negedge aclk);
    checks++;
    if (regs_o !== m_flat()) $display("[TB] FAIL mid_recover_regs: got %h, required %h", regs_o, m_flat());
    else passes++;
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b0;
    model_clear();
    test_reset();
    test_write_aw_first();
    test_partial_strobe();
    test_zero_strobe();
    test_back_to_back_bp();
    test_read_backpressure();
    test_addr_mode();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
